// File: rtl/hdmi_cfg_pkg.sv
// Shared types and register table for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

    localparam int unsigned CFG_LEN   = 16;
    localparam int unsigned CFG_IDX_W = $clog2(CFG_LEN);

    typedef enum logic [3:0] {
        StIdle,
        StWaitHpd,
        StDelay,
        StWr,
        StWrRsp,
        StRd,
        StRdRsp,
        StNext,
        StDone,
        StErr
    } cfg_state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
        logic [7:0] mask;
    } cfg_entry_t;

    // Mask selects the bits that read back deterministically.
    localparam cfg_entry_t CFG_TABLE [CFG_LEN] = '{
        '{8'h41, 8'h10, 8'hFF},
        '{8'h98, 8'h03, 8'hFF},
        '{8'h9A, 8'hE0, 8'hE0},
        '{8'h9C, 8'h30, 8'hFF},
        '{8'h9D, 8'h61, 8'hFF},
        '{8'hA2, 8'hA4, 8'hFF},
        '{8'hA3, 8'hA4, 8'hFF},
        '{8'hE0, 8'hD0, 8'hFF},
        '{8'hF9, 8'h00, 8'hFF},
        '{8'h15, 8'h00, 8'h0F},
        '{8'h16, 8'h30, 8'hFF},
        '{8'h17, 8'h02, 8'hFF},
        '{8'h18, 8'h46, 8'hFF},
        '{8'hAF, 8'h06, 8'hFF},
        '{8'h40, 8'h80, 8'hC0},
        '{8'hD6, 8'hC0, 8'hC0}
    };

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Combinational lookup of one configuration table entry.
module hdmi_cfg_rom
    import hdmi_cfg_pkg::*;
(
    input  logic [4:0] i_entry_idx,
    output cfg_entry_t o_entry
);

    always_comb begin
        o_entry = '0;
        if (i_entry_idx < 5'(CFG_LEN)) begin
            o_entry = CFG_TABLE[i_entry_idx[CFG_IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/hdmi_tx_cfg_seq.sv
// Writes the HDMI transmitter register table over an I2C command port after hot-plug.
// Optional write-then-read verification is enabled by defining HDMI_CFG_READBACK_EN.
module hdmi_tx_cfg_seq
    import hdmi_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h39,
    parameter int unsigned DELAY_CYC = 200000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       hpd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [6:0] cmd_dev,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_wdata,
    output logic       cmd_rnw,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] entry_idx
);

    localparam int unsigned       DLY_W     = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(DELAY_CYC - 1);
    localparam logic [1:0]        RETRY_LIM = 2'(MAX_RETRY);
    localparam logic [4:0]        LAST_IDX  = 5'(CFG_LEN - 1);

    cfg_state_e       r_state, w_state_next;
    logic [DLY_W-1:0] r_dly, w_dly_next;
    logic [4:0]       r_idx, w_idx_next;
    logic [1:0]       r_retry, w_retry_next;
    logic             r_hpd;
    logic             r_abort, w_abort_next;
    logic             r_abort_dly, w_abort_dly_next;

    cfg_entry_t w_entry;
    logic       w_busy, w_hpd_fall, w_restart, w_abort, w_go_dly, w_fire, w_fail, w_do_abort;

    hdmi_cfg_rom u_rom (
        .i_entry_idx (r_idx),
        .o_entry     (w_entry)
    );

    assign w_busy     = (r_state != StIdle) && (r_state != StDone) && (r_state != StErr);
    assign w_hpd_fall = r_hpd & ~hpd;
    assign w_restart  = start & w_busy;
    assign w_abort    = w_hpd_fall | w_restart;
    // A falling hpd forces hpd=0 here, which is what gives it priority over start.
    assign w_go_dly   = hpd & (w_restart | r_abort_dly);
    assign w_fire     = cmd_valid & cmd_ready;

`ifdef HDMI_CFG_READBACK_EN
    assign w_fail = rsp_nack |
                    ((r_state == StRdRsp) &&
                     (((rsp_rdata ^ w_entry.data) & w_entry.mask) != 8'h00));
`else
    logic w_unused;
    assign w_unused = ^{rsp_rdata, w_entry.mask};
    assign w_fail   = rsp_nack;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_dly       <= '0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_hpd       <= 1'b0;
            r_abort     <= 1'b0;
            r_abort_dly <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dly       <= w_dly_next;
            r_idx       <= w_idx_next;
            r_retry     <= w_retry_next;
            r_hpd       <= hpd;
            r_abort     <= w_abort_next;
            r_abort_dly <= w_abort_dly_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_dly_next       = r_dly;
        w_idx_next       = r_idx;
        w_retry_next     = r_retry;
        w_abort_next     = r_abort;
        w_abort_dly_next = r_abort_dly;
        w_do_abort       = 1'b0;
        if (w_abort) begin
            w_abort_dly_next = w_restart & ~w_hpd_fall;
        end

        case (r_state)
            StIdle, StDone, StErr: begin
                if (start || w_hpd_fall) begin
                    w_state_next = StWaitHpd;
                    w_idx_next   = '0;
                    w_retry_next = '0;
                end
            end
            StWaitHpd: begin
                if (w_abort) begin
                    w_do_abort = 1'b1;
                end else if (hpd) begin
                    w_state_next = StDelay;
                    w_dly_next   = DLY_LOAD;
                end
            end
            StDelay: begin
                if (w_abort) begin
                    w_do_abort = 1'b1;
                end else if (r_dly == '0) begin
                    w_state_next = StWr;
                end else begin
                    w_dly_next = r_dly - 1'b1;
                end
            end
            StWr, StRd: begin
                // A command accepted in the abort cycle is outstanding and must be drained.
                if (w_fire) begin
                    w_state_next = (r_state == StWr) ? StWrRsp : StRdRsp;
                    w_abort_next = w_abort;
                end else if (w_abort) begin
                    w_do_abort = 1'b1;
                end
            end
            StWrRsp, StRdRsp: begin
                if (w_abort) begin
                    w_abort_next = 1'b1;
                end
                if (rsp_valid) begin
                    if (w_abort || r_abort) begin
                        w_do_abort = 1'b1;
                    end else if (w_fail) begin
                        if (r_retry == RETRY_LIM) begin
                            w_state_next = StErr;
                        end else begin
                            w_retry_next = r_retry + 2'd1;
                            w_state_next = StWr;
                        end
                    end
`ifdef HDMI_CFG_READBACK_EN
                    else if (r_state == StWrRsp) begin
                        w_state_next = StRd;
                    end
`endif
                    else begin
                        w_retry_next = '0;
                        w_state_next = StNext;
                    end
                end
            end
            StNext: begin
                if (w_abort) begin
                    w_do_abort = 1'b1;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = StDone;
                end else begin
                    w_idx_next   = r_idx + 5'd1;
                    w_state_next = StWr;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (w_do_abort) begin
            w_state_next     = w_go_dly ? StDelay : StWaitHpd;
            w_dly_next       = DLY_LOAD;
            w_idx_next       = '0;
            w_retry_next     = '0;
            w_abort_next     = 1'b0;
            w_abort_dly_next = 1'b0;
        end
    end

    assign cmd_valid = (r_state == StWr) || (r_state == StRd);
    assign cmd_dev   = DEV_ADDR;
    assign cmd_reg   = w_entry.reg_addr;
    assign cmd_wdata = w_entry.data;
`ifdef HDMI_CFG_READBACK_EN
    assign cmd_rnw   = (r_state == StRd);
`else
    assign cmd_rnw   = 1'b0;
`endif
    assign busy      = w_busy;
    assign done      = (r_state == StDone);
    assign error     = (r_state == StErr);
    assign entry_idx = r_idx;

endmodule
